// File: rtl/digit_codes_pkg.sv
// Digit codes and converter FSM state encodings shared by bin_to_digits and the display driver.
package digit_codes;

  localparam logic [4:0] DIG_BLANK = 5'd16;
  localparam logic [4:0] DIG_DASH  = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    UPDT = 2'd2
  } state_t;

  function automatic logic [4:0] nibble_code(input logic [3:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/bin_to_digits_bcd_adj3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more before the shift.
module bcd_adj3 (
  input  logic [3:0] in,
  output logic [3:0] out
);

  always_comb begin
    out = in;
    if (in >= 4'd5) out = in + 4'd3;
  end

endmodule

// File: rtl/bin_to_digits.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) producing 7-seg digit codes.
// Optional leading-zero blanking of tens/hundreds: define BIN_TO_DIGITS_LZ_BLANK_EN.
module bin_to_digits
  import digit_codes::*;
#(
  parameter int IN_W    = 10,
  parameter int MAX_VAL = 999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [4:0]      u,
  output logic [4:0]      d,
  output logic [4:0]      c
);

  if (IN_W < 4 || IN_W > 10) begin : g_bad_width
    $error("bin_to_digits: IN_W must be in 4..10");
  end

  state_t            state;
  logic [3:0]        cnt;
  logic [IN_W-1:0]   bin;
  logic [11:0]       bcd;
  logic              ovf;
  logic [3:0]        adj_u;
  logic [3:0]        adj_d;
  logic [3:0]        adj_c;
  logic [4:0]        res_u;
  logic [4:0]        res_d;
  logic [4:0]        res_c;

  bcd_adj3 adj_units    (.in(bcd[3:0]),  .out(adj_u));
  bcd_adj3 adj_tens     (.in(bcd[7:4]),  .out(adj_d));
  bcd_adj3 adj_hundreds (.in(bcd[11:8]), .out(adj_c));

  // Final digit codes, computed from the completed scratch so u/d/c only ever see full results.
  always_comb begin
    res_u = nibble_code(bcd[3:0]);
    res_d = nibble_code(bcd[7:4]);
    res_c = nibble_code(bcd[11:8]);
`ifdef BIN_TO_DIGITS_LZ_BLANK_EN
    if (bcd[11:8] == 4'd0) begin
      res_c = DIG_BLANK;
      if (bcd[7:4] == 4'd0) res_d = DIG_BLANK;
    end
`endif
    if (ovf) begin
      res_u = DIG_DASH;
      res_d = DIG_DASH;
      res_c = DIG_DASH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      u     <= DIG_BLANK;
      d     <= DIG_BLANK;
      c     <= DIG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin   <= value;
            bcd   <= '0;
            cnt   <= '0;
            ovf   <= (32'(value) > 32'(MAX_VAL));
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {adj_c, adj_d, adj_u, bin} << 1;
          cnt        <= cnt + 4'd1;
          if (cnt == 4'(IN_W - 1)) state <= UPDT;
        end
        UPDT: begin
          u     <= res_u;
          d     <= res_d;
          c     <= res_c;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_digits.sv
// Directed self-checking bench for bin_to_digits (default IN_W = 10, MAX_VAL = 999).
module tb_bin_to_digits;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] value;
  logic       busy;
  logic       done;
  logic [4:0] u;
  logic [4:0] d;
  logic [4:0] c;

  int n_checks;
  int n_fails;

`ifdef BIN_TO_DIGITS_LZ_BLANK_EN
  localparam logic [4:0] LZ = 5'd16;
`else
  localparam logic [4:0] LZ = 5'd0;
`endif

  bin_to_digits #(.IN_W(10), .MAX_VAL(999)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .u     (u),
    .d     (d),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Accept a start at the next rising edge and wait (bounded) for done.
  task automatic conv(input string tag, input logic [9:0] v,
                      input logic [4:0] ec, input logic [4:0] ed, input logic [4:0] eu);
    int lat;
    int busy_cnt;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 21;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, lat, 11);
    check({tag, " busy cycles"}, busy_cnt, 11);
    check({tag, " busy low at done"}, busy, 0);
    check({tag, " c"}, c, ec);
    check({tag, " d"}, d, ed);
    check({tag, " u"}, u, eu);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    start    = 1'b0;
    value    = '0;
    rst      = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("reset u", u, 16);
    check("reset d", d, 16);
    check("reset c", c, 16);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    #10 rst = 1'b0;

    conv("v255", 10'd255, 5'd2, 5'd5, 5'd5);
    @(posedge clk);
    #1 check("v255 done one cycle", done, 0);
    check("v255 hold u", u, 5);

    conv("v7", 10'd7, LZ, LZ, 5'd7);
    conv("v1000", 10'd1000, 5'd17, 5'd17, 5'd17);
    conv("v0", 10'd0, LZ, LZ, 5'd0);
    conv("v999", 10'd999, 5'd9, 5'd9, 5'd9);
    conv("v40", 10'd40, LZ, 5'd4, 5'd0);

    // Start 123, then pulse start with 456 mid-conversion; the pulse must be ignored.
    fork
      conv("v123", 10'd123, 5'd1, 5'd2, 5'd3);
      begin
        repeat (4) @(negedge clk);
        value = 10'd456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 10'd123;
      end
    join
    // Back-to-back: start raised during the done cycle is accepted at the next edge.
    value = 10'd456;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b busy", busy, 1);
    begin
      int lat;
      lat = 21;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = k;
          break;
        end
      end
      check("v456 latency", lat, 11);
    end
    check("v456 c", c, 4);
    check("v456 d", d, 5);
    check("v456 u", u, 6);
    count_dones("no queued done", 15);

    // Reset in the middle of a conversion.
    @(negedge clk);
    value = 10'd255;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst u", u, 16);
    check("midrst d", d, 16);
    check("midrst c", c, 16);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones("midrst no done", 15);
    check("midrst u hold", u, 16);
    conv("v42", 10'd42, LZ, 5'd4, 5'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
